if_id_stage: RTL and testbench

//  IF/ID pipeline stage of the MIPS core. Registers each fetched instruction and its PC

---
 rtl/if_id_stage.sv | 122 ++++++++++++
 tb/tb_if_id_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: 2-entry skid buffer with valid/ready on both sides,
// plus combinational decode-field slicing of the head entry.
module if_id_stage #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc4,
  output logic [INSTR_W-1:0] out_instr,
  output logic [5:0]         out_opcode,
  output logic [4:0]         out_rs,
  output logic [4:0]         out_rt,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_shamt,
  output logic [5:0]         out_funct,
  output logic [15:0]        out_imm,
  output logic               out_imm_sign,
  output logic [25:0]        out_jidx
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_e;

  state_e             state_q, state_d;
  logic               main_vld_q, main_vld_d;
  logic               skid_vld_q, skid_vld_d;
  logic               in_ready_q, in_ready_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               acc, pop;

  assign acc = in_valid & in_ready_q;
  assign pop = main_vld_q & out_ready;

  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    case (state_q)
      EMPTY: if (acc) begin
        state_d      = FULL;
        main_pc_d    = in_pc;
        main_instr_d = in_instr;
      end
      FULL: begin
        if (acc && pop) begin
          main_pc_d    = in_pc;
          main_instr_d = in_instr;
        end else if (pop) begin
          state_d = EMPTY;
        end else if (acc) begin
          state_d      = SKID;
          skid_pc_d    = in_pc;
          skid_instr_d = in_instr;
        end
      end
      SKID: if (pop) begin
        state_d      = FULL;
        main_pc_d    = skid_pc_q;
        main_instr_d = skid_instr_q;
      end
      default: state_d = EMPTY;
    endcase
    // Flush squashes everything; data registers keep stale contents behind cleared valids.
    if (flush) state_d = EMPTY;
    main_vld_d = (state_d != EMPTY);
    skid_vld_d = (state_d == SKID);
    in_ready_d = (state_d != SKID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_vld_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      main_pc_q    <= '0;
      main_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      main_vld_q   <= main_vld_d;
      skid_vld_q   <= skid_vld_d;
      in_ready_q   <= in_ready_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  logic unused_skid_vld;
  assign unused_skid_vld = skid_vld_q;

  assign in_ready     = in_ready_q;
  assign out_valid    = main_vld_q;
  assign out_pc4      = main_pc_q + PC_W'(4);
  assign out_instr    = main_instr_q;
  assign out_opcode   = main_instr_q[31:26];
  assign out_rs       = main_instr_q[25:21];
  assign out_rt       = main_instr_q[20:16];
  assign out_rd       = main_instr_q[15:11];
  assign out_shamt    = main_instr_q[10:6];
  assign out_funct    = main_instr_q[5:0];
  assign out_imm      = main_instr_q[15:0];
  assign out_jidx     = main_instr_q[25:0];
  // Logical immediates (andi/ori/xori/lui, opcodes 0x0C-0x0F) zero-extend.
  assign out_imm_sign = (main_instr_q[31:28] != 4'b0011);

endmodule

// File: tb/tb_if_id_stage.sv
// Directed/table-driven bench for if_id_stage with a FIFO scoreboard for random traffic.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc4, out_instr;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_imm;
  logic        out_imm_sign;
  logic [25:0] out_jidx;

  int total = 0;
  int passed = 0;

  if_id_stage #(.PC_W(32), .INSTR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc4(out_pc4), .out_instr(out_instr),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm(out_imm),
    .out_imm_sign(out_imm_sign), .out_jidx(out_jidx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    in_valid = 1'b1; in_pc = pc; in_instr = ins;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        sign;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] sb_pc[$];
  logic [31:0] sb_ins[$];

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h2008FFFF, 32'h0000_0004, 6'h08, 5'd0, 5'd8,  5'd31, 16'hFFFF, 1'b1};
    vecs[1] = '{32'h0000_0004, 32'h3508FFFF, 32'h0000_0008, 6'h0D, 5'd8, 5'd8,  5'd31, 16'hFFFF, 1'b0};
    vecs[2] = '{32'h0000_0008, 32'h8D090004, 32'h0000_000C, 6'h23, 5'd8, 5'd9,  5'd0,  16'h0004, 1'b1};
    vecs[3] = '{32'hFFFF_FFFC, 32'h012A4020, 32'h0000_0000, 6'h00, 5'd9, 5'd10, 5'd8,  16'h4020, 1'b1};
    vecs[4] = '{32'h0000_0100, 32'h3C01ABCD, 32'h0000_0104, 6'h0F, 5'd0, 5'd1,  5'd21, 16'hABCD, 1'b0};
    vecs[5] = '{32'h0000_0104, 32'h3021000F, 32'h0000_0108, 6'h0C, 5'd1, 5'd1,  5'd0,  16'h000F, 1'b0};
    vecs[6] = '{32'h7FFF_FFFC, 32'h3842FFFF, 32'h8000_0000, 6'h0E, 5'd2, 5'd2,  5'd31, 16'hFFFF, 1'b0};
    vecs[7] = '{32'h0000_0200, 32'h2862FFFF, 32'h0000_0204, 6'h0A, 5'd3, 5'd2,  5'd31, 16'hFFFF, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;

    // Reset held two cycles
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc4",   out_pc4, 32'h4);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // Streaming table, out_ready held high: each vector appears one cycle after push
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_pc = vecs[i].pc; in_instr = vecs[i].instr;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      chk($sformatf("v%0d_instr", i), out_instr, vecs[i].instr);
      chk($sformatf("v%0d_pc4", i), out_pc4, vecs[i].pc4);
      chk($sformatf("v%0d_opcode", i), out_opcode, vecs[i].op);
      chk($sformatf("v%0d_rs", i), out_rs, vecs[i].rs);
      chk($sformatf("v%0d_rt", i), out_rt, vecs[i].rt);
      chk($sformatf("v%0d_rd", i), out_rd, vecs[i].rd);
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d_imm_sign", i), out_imm_sign, vecs[i].sign);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_drained", out_valid, 0);

    // Remaining add fields
    push(32'hFFFF_FFFC, 32'h012A4020);
    chk("add_shamt", out_shamt, 0);
    chk("add_funct", out_funct, 6'h20);
    chk("add_jidx",  out_jidx, 26'h12A4020);
    @(negedge clk);

    // Backpressure: A then B, hold, then release
    out_ready = 1'b0;
    push(32'h1000, 32'hAAAA_0001);
    chk("bp_full_valid", out_valid, 1);
    chk("bp_full_in_ready", in_ready, 1);
    chk("bp_full_instr", out_instr, 32'hAAAA_0001);
    push(32'h2000, 32'hBBBB_0002);
    chk("bp_skid_in_ready", in_ready, 0);
    chk("bp_skid_instr", out_instr, 32'hAAAA_0001);
    in_valid = 1'b1; in_pc = 32'h3000; in_instr = 32'hDEAD_0003;  // blocked, must not be taken
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_hold_instr", out_instr, 32'hAAAA_0001);
    chk("bp_hold_pc4", out_pc4, 32'h1004);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_valid", out_valid, 1);
    chk("bp_b_instr", out_instr, 32'hBBBB_0002);
    chk("bp_b_in_ready", in_ready, 1);
    @(negedge clk);
    chk("bp_done", out_valid, 0);

    // Flush in SKID with an input presented
    out_ready = 1'b0;
    push(32'h4000, 32'h1111_0001);
    push(32'h4004, 32'h2222_0002);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h4008; in_instr = 32'hCCCC_0003;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_no_c", out_valid, 0);
    push(32'h5000, 32'hDDDD_0004);
    chk("flush_next_instr", out_instr, 32'hDDDD_0004);
    @(negedge clk);

    // Flush while input presented in EMPTY drops it
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hEEEE_0005;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_empty_drop", out_valid, 0);

    // Reset mid-transfer
    out_ready = 1'b0;
    push(32'h6000, 32'h3333_0001);
    push(32'h6004, 32'h4444_0002);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    chk("rst_mid_instr", out_instr, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_release", in_ready, 1);
    chk("rst_mid_empty", out_valid, 0);

    // Random traffic against a FIFO scoreboard
    for (int c = 0; c < 60; c++) begin
      logic ir, acc, pop;
      chk("rnd_out_valid", out_valid, (sb_ins.size() != 0));
      chk("rnd_in_ready", in_ready, (sb_ins.size() < 2));
      ir = in_ready;
      in_valid  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      in_pc     = 32'h8000 + 32'(c * 4);
      in_instr  = $urandom;
      #1;
      chk("rnd_in_ready_no_comb", in_ready, ir);
      acc = in_valid & in_ready;
      pop = out_valid & out_ready;
      if (pop) begin
        chk("rnd_head_instr", out_instr, sb_ins[0]);
        chk("rnd_head_pc4", out_pc4, sb_pc[0] + 32'd4);
        void'(sb_ins.pop_front());
        void'(sb_pc.pop_front());
      end
      if (acc) begin
        sb_ins.push_back(in_instr);
        sb_pc.push_back(in_pc);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
